// File: rtl/cc_line_serializer.sv
// cc_line_serializer: pops cache-line entries from a show-ahead FIFO and replays them as R bursts
module cc_line_serializer #(
  parameter int LINE_W = 512,
  parameter int BEAT_W = 64,
  parameter int ID_W = 4,
  localparam int NBEATS = LINE_W / BEAT_W,
  localparam int OFF_W = $clog2(NBEATS),
  localparam int ENT_W = ID_W + 1 + OFF_W + LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty_i,
  input  logic [ENT_W-1:0]  fifo_rdata_i,
  output logic              fifo_rden_o,
  output logic [ID_W-1:0]   rid_o,
  output logic [BEAT_W-1:0] rdata_o,
  output logic              rlast_o,
  output logic              rvalid_o,
  input  logic              rready_i
);
  logic busy;
  logic [LINE_W-1:0] line_q, line;
  logic [ID_W-1:0] id_q, id;
  logic [OFF_W-1:0] idx_q, last_idx_q, off;
  logic wrap;
  logic [BEAT_W-1:0] words [NBEATS];
  assign {id, wrap, off, line} = fifo_rdata_i;
  for (genvar i = 0; i < NBEATS; i++) begin : g_word
    assign words[i] = line_q[LINE_W-1-i*BEAT_W -: BEAT_W];
  end
  assign rvalid_o = busy;
  assign rlast_o = busy && (idx_q == last_idx_q);
  assign rid_o = id_q;
  assign rdata_o = words[idx_q];
  // a final-beat accept and the next pop share a cycle, so lines stream without a bubble
  assign fifo_rden_o = !fifo_empty_i && (!busy || (rvalid_o && rready_i && rlast_o));
  always_ff @(posedge clk)
    if (!rst_n) begin
      busy <= 1'b0;
      line_q <= '0;
      id_q <= '0;
      idx_q <= '0;
      last_idx_q <= '0;
    end else if (fifo_rden_o) begin
      busy <= 1'b1;
      line_q <= line;
      id_q <= id;
      idx_q <= off;
      last_idx_q <= wrap ? off - 1'b1 : '1;
    end else if (rvalid_o && rready_i) begin
      busy <= !rlast_o;
      idx_q <= idx_q + 1'b1;
    end
endmodule

// File: tb/tb_cc_line_serializer.sv
// tb_cc_line_serializer: directed bench for the default and a narrow instance, with a per-beat burst model
module tb_cc_line_serializer;
  typedef struct packed {
    logic [3:0]   id;
    logic         wrap;
    logic [3:0]   off;
    logic [511:0] line;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  ent_t fmem [2][64];
  int tail [2];
  logic rst_n [2];
  logic rready [2];

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mkline(input int lw, input int bw);
    logic [511:0] l = '0;
    for (int k = 0; k < lw / bw; k++)
      for (int n = 0; n < bw / 4; n++) l[lw-1-k*bw-4*n -: 4] = 4'(k);
    return l;
  endfunction

  task automatic push(input int g, input int id, input bit wrap, input int off);
    ent_t e;
    e.id = 4'(id);
    e.wrap = wrap;
    e.off = 4'(off);
    e.line = mkline(g ? 256 : 512, g ? 32 : 64);
    fmem[g][tail[g] % 64] = e;
    tail[g]++;
  endtask

  for (genvar g = 0; g < 2; g++) begin : b
    localparam int LW = g ? 256 : 512;
    localparam int BW = g ? 32 : 64;
    localparam int IW = g ? 2 : 4;
    localparam int NB = LW / BW;
    localparam int OW = $clog2(NB);
    localparam int EW = IW + 1 + OW + LW;
    int head = 0, ce = 0, j = 0, nl = 0, vrun = 0, vmax = 0, npop = 0;
    logic empty, rden, rvalid, rlast, pv, pr, pl;
    logic [BW-1:0] rdata, pd;
    logic [IW-1:0] rid, pid;
    ent_t fe;
    logic [EW-1:0] ent;
    logic [63:0] lgd [256];
    logic lgl [256];
    assign fe = fmem[g][head % 64];
    assign empty = head == tail[g];
    assign ent = {fe.id[IW-1:0], fe.wrap, fe.off[OW-1:0], fe.line[LW-1:0]};

    cc_line_serializer #(.LINE_W(LW), .BEAT_W(BW), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n[g]), .fifo_empty_i(empty), .fifo_rdata_i(ent),
      .fifo_rden_o(rden), .rid_o(rid), .rdata_o(rdata), .rlast_o(rlast),
      .rvalid_o(rvalid), .rready_i(rready[g]));

    always @(posedge clk) if (rden) head <= head + 1;

    // model: entry ce, beat j of its burst; expected word, id and last derived from the entry fields
    always @(negedge clk) begin
      int n, w;
      ent_t e;
      logic [BW-1:0] ew;
      if (!rst_n[g]) begin
        ce = head;
        j = 0;
        pv = 1'b0;
        vrun = 0;
      end else begin
        chk(!(rden && empty), "pop_when_empty", rden, 0);
        if (pv && !pr)
          chk(rvalid && rdata == pd && rid == pid && rlast == pl, "stall_hold", rdata, pd);
        if (rvalid && rden) chk(rlast && rready[g], "pop_midburst", rlast, 1);
        if (rvalid && rready[g]) begin
          chk(ce < tail[g], "extra_beat", ce, tail[g]);
          if (ce < tail[g]) begin
            e = fmem[g][ce % 64];
            n = e.wrap ? NB : NB - int'(e.off);
            w = (int'(e.off) + j) % NB;
            ew = e.line[LW-1-w*BW -: BW];
            chk(rdata == ew, "beat_data", rdata, ew);
            chk(rid == e.id[IW-1:0], "beat_id", rid, e.id[IW-1:0]);
            chk(rlast == (j == n - 1), "beat_last", rlast, j == n - 1);
            lgd[nl] = 64'(rdata);
            lgl[nl] = rlast;
            nl++;
            j++;
            if (j == n) begin
              ce++;
              j = 0;
            end
          end
        end
        vrun = rvalid ? vrun + 1 : 0;
        if (vrun > vmax) vmax = vrun;
        if (rden) npop++;
        pv = rvalid;
        pr = rready[g];
        pd = rdata;
        pid = rid;
        pl = rlast;
      end
    end
  end

  task automatic wait_done(input int g, input string nm);
    int c = 0;
    bit done;
    done = g ? b[1].ce == tail[1] : b[0].ce == tail[0];
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
      done = g ? b[1].ce == tail[1] : b[0].ce == tail[0];
    end
    chk(done, {nm, "_timeout"}, c, 200);
  endtask

  task automatic chk_seq(input int g, input int s, input int ord[8], input int n, input string nm);
    int cnt;
    longint d, exp;
    logic l;
    cnt = g ? b[1].nl : b[0].nl;
    chk(cnt - s == n, {nm, "_count"}, cnt - s, n);
    for (int i = 0; i < n; i++) begin
      d = g ? b[1].lgd[s+i] : b[0].lgd[s+i];
      l = g ? b[1].lgl[s+i] : b[0].lgl[s+i];
      exp = ord[i] * (g ? 64'h11111111 : 64'h1111111111111111);
      chk(d == exp, {nm, "_word"}, d, exp);
      chk(l == (i == n - 1), {nm, "_last"}, l, i == n - 1);
    end
  endtask

  initial begin
    int s, c;
    rst_n = '{1'b0, 1'b0};
    rready = '{1'b0, 1'b0};
    tail = '{0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(b[0].rvalid == 0, "rst_rvalid", b[0].rvalid, 0);
    chk(b[0].rlast == 0, "rst_rlast", b[0].rlast, 0);
    chk(b[0].rden == 0, "rst_rden", b[0].rden, 0);
    chk(b[0].rdata == 0, "rst_rdata", b[0].rdata, 0);
    chk(b[0].rid == 0, "rst_rid", b[0].rid, 0);
    @(posedge clk) #1;
    rst_n = '{1'b1, 1'b1};
    @(negedge clk);
    chk(b[0].rvalid == 0, "idle_rvalid", b[0].rvalid, 0);

    // wrap burst, offset 5, with latency check
    rready[0] = 1'b1;
    s = b[0].nl;
    c = b[0].npop;
    @(posedge clk) #1;
    push(0, 3, 1, 5);
    @(negedge clk);
    chk(b[0].rden == 1, "lat_rden", b[0].rden, 1);
    chk(b[0].rvalid == 0, "lat_idle", b[0].rvalid, 0);
    @(negedge clk);
    chk(b[0].rvalid == 1, "lat_first", b[0].rvalid, 1);
    chk(b[0].rdata == 64'h5555555555555555, "first_data", b[0].rdata, 64'h5555555555555555);
    chk(b[0].rid == 4'd3, "first_id", b[0].rid, 3);
    wait_done(0, "wrap5");
    chk_seq(0, s, '{5, 6, 7, 0, 1, 2, 3, 4}, 8, "wrap5");
    chk(b[0].npop - c == 1, "wrap5_pops", b[0].npop - c, 1);

    // incrementing bursts
    repeat (2) @(posedge clk);
    s = b[0].nl;
    @(posedge clk) #1;
    push(0, 1, 0, 5);
    wait_done(0, "incr5");
    chk_seq(0, s, '{5, 6, 7, 0, 0, 0, 0, 0}, 3, "incr5");
    repeat (2) @(posedge clk);
    s = b[0].nl;
    @(posedge clk) #1;
    push(0, 2, 0, 7);
    wait_done(0, "incr7");
    chk_seq(0, s, '{7, 0, 0, 0, 0, 0, 0, 0}, 1, "incr7");

    // back-to-back wrap lines from offset 0
    repeat (2) @(posedge clk);
    s = b[0].nl;
    c = b[0].npop;
    @(posedge clk) #1;
    push(0, 4, 1, 0);
    push(0, 5, 1, 0);
    wait_done(0, "b2b");
    chk(b[0].vmax == 16, "b2b_run", b[0].vmax, 16);
    chk(b[0].npop - c == 2, "b2b_pops", b[0].npop - c, 2);
    chk(b[0].nl - s == 16, "b2b_beats", b[0].nl - s, 16);

    // backpressure
    repeat (2) @(posedge clk);
    s = b[0].nl;
    rready[0] = 1'b0;
    @(posedge clk) #1;
    push(0, 3, 1, 5);
    c = 0;
    while (b[0].ce != tail[0] && c < 400) begin
      @(posedge clk) #1;
      rready[0] = (c < 3) ? 1'b0 : 1'($urandom_range(0, 1));
      c++;
    end
    chk(b[0].ce == tail[0], "bp_timeout", c, 400);
    chk_seq(0, s, '{5, 6, 7, 0, 1, 2, 3, 4}, 8, "bp");

    // reset after three accepted beats, then a clean restart
    rready[0] = 1'b1;
    repeat (2) @(posedge clk);
    s = b[0].nl;
    @(posedge clk) #1;
    push(0, 6, 1, 2);
    c = 0;
    while (b[0].nl < s + 3 && c < 50) begin
      @(posedge clk) #1;
      c++;
    end
    chk(b[0].nl - s == 3, "mid_beats", b[0].nl - s, 3);
    rst_n[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(b[0].rvalid == 0, "mid_rst_rvalid", b[0].rvalid, 0);
    chk(b[0].rlast == 0, "mid_rst_rlast", b[0].rlast, 0);
    @(posedge clk) #1;
    rst_n[0] = 1'b1;
    s = b[0].nl;
    push(0, 7, 1, 3);
    wait_done(0, "restart");
    chk_seq(0, s, '{3, 4, 5, 6, 7, 0, 1, 2}, 8, "restart");

    // narrow instance: 256-bit line, 32-bit beats
    rready[1] = 1'b1;
    s = b[1].nl;
    @(posedge clk) #1;
    push(1, 1, 1, 6);
    wait_done(1, "p256");
    chk_seq(1, s, '{6, 7, 0, 1, 2, 3, 4, 5}, 8, "p256");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
